ex_mem_reg: RTL and testbench

- Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS32 core.
- Latches the EX-stage results and presents them to the MEM stage on the following cycle.
- Implements stall bubbles and pipeline flush.
- Carries the two-cycle multiply-accumulate (madd/maddu/msub/msubu) intermediate value and the cycle counter back to EX while the pipeline is stalled.

---
 rtl/ex_mem_reg.sv | 113 +++++++++++
 tb/tb_ex_mem_reg.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush, bubble and hold, plus the multiply-accumulate feedback path to EX.
// Optional exception fields are enabled by defining EXMEM_EXCEPT_EN.
module ex_mem_reg #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 8,
  parameter int ALUSEL_W  = 3,
  parameter int CNT_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [REGADDR_W-1:0]  ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [CNT_W-1:0]      cnt_i,
`ifdef EXMEM_EXCEPT_EN
  input  logic [31:0]           ex_excepttype,
  input  logic [DATA_W-1:0]     ex_inst_addr,
  input  logic                  ex_in_delayslot,
  output logic [31:0]           mem_excepttype,
  output logic [DATA_W-1:0]     mem_inst_addr,
  output logic                  mem_in_delayslot,
`endif
  output logic [REGADDR_W-1:0]  mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [CNT_W-1:0]      cnt_o
);

  // All mem_* fields share identical update rules, so they travel as one packed word.
`ifdef EXMEM_EXCEPT_EN
  localparam int EXC_W = 32 + DATA_W + 1;
`else
  localparam int EXC_W = 0;
`endif
  localparam int PIPE_W = REGADDR_W + 2 + 5*DATA_W + ALUOP_W + EXC_W;

  logic [PIPE_W-1:0]   ex_pipe;
  logic [PIPE_W-1:0]   mem_pipe_d, mem_pipe_q;
  logic [2*DATA_W-1:0] hilo_d, hilo_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                bubble, hold;

`ifdef EXMEM_EXCEPT_EN
  assign ex_pipe = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
                    ex_mem_addr, ex_reg2, ex_excepttype, ex_inst_addr, ex_in_delayslot};
  assign {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
          mem_mem_addr, mem_reg2, mem_excepttype, mem_inst_addr, mem_in_delayslot} = mem_pipe_q;
`else
  assign ex_pipe = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
                    ex_mem_addr, ex_reg2};
  assign {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
          mem_mem_addr, mem_reg2} = mem_pipe_q;
`endif

  assign bubble = stall[3] & ~stall[4];
  assign hold   = stall[3] &  stall[4];

  always_comb begin
    mem_pipe_d = ex_pipe;
    hilo_d     = '0;
    cnt_d      = '0;
    if (flush) begin
      mem_pipe_d = '0;
    end else if (bubble) begin
      mem_pipe_d = '0;
      hilo_d     = hilo_i;
      cnt_d      = cnt_i;
    end else if (hold) begin
      mem_pipe_d = mem_pipe_q;
      hilo_d     = hilo_i;
      cnt_d      = cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_pipe_q <= '0;
      hilo_q     <= '0;
      cnt_q      <= '0;
    end else begin
      mem_pipe_q <= mem_pipe_d;
      hilo_q     <= hilo_d;
      cnt_q      <= cnt_d;
    end
  end

  assign hilo_o = hilo_q;
  assign cnt_o  = cnt_q;

`ifndef SYNTHESIS
  // The control unit must never stall MEM while EX runs; the RTL then simply advances.
  a_no_mem_only_stall: assert property (@(posedge clk) disable iff (rst)
                                        !(!stall[3] && stall[4]));
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, advance, bubble, hold, flush and accumulate sequences.
module tb_ex_mem_reg;
  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int failures = 0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wd"},    64'(mem_wd), 64'd0);
    chk({tag, ".wreg"},  64'(mem_wreg), 64'd0);
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, ".hi"},    64'(mem_hi), 64'd0);
    chk({tag, ".lo"},    64'(mem_lo), 64'd0);
    chk({tag, ".whilo"}, 64'(mem_whilo), 64'd0);
    chk({tag, ".aluop"}, 64'(mem_aluop), 64'd0);
    chk({tag, ".addr"},  64'(mem_mem_addr), 64'd0);
    chk({tag, ".reg2"},  64'(mem_reg2), 64'd0);
    chk({tag, ".hilo"},  hilo_o, 64'd0);
    chk({tag, ".cnt"},   64'(cnt_o), 64'd0);
  endtask

  initial begin
    // reset with every input nonzero
    rst = 1'b1; flush = 1'b1; stall = 6'b011111;
    ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF; ex_hi = 32'h11111111;
    ex_lo = 32'h22222222; ex_whilo = 1'b1; ex_aluop = 8'h55; ex_mem_addr = 32'h33333333;
    ex_reg2 = 32'h44444444; hilo_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'd3;
    step();
    chk_all_zero("rst1");
    flush = 1'b0; stall = 6'b000000;
    step();
    chk_all_zero("rst2");

    // advance
    rst = 1'b0;
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h12345678; ex_aluop = 8'h23;
    ex_mem_addr = 32'h00001000; ex_reg2 = 32'hCAFEF00D; ex_whilo = 1'b0;
    step();
    chk("adv.wd",    64'(mem_wd), 64'd3);
    chk("adv.wreg",  64'(mem_wreg), 64'd1);
    chk("adv.wdata", 64'(mem_wdata), 64'h12345678);
    chk("adv.aluop", 64'(mem_aluop), 64'h23);
    chk("adv.addr",  64'(mem_mem_addr), 64'h00001000);
    chk("adv.reg2",  64'(mem_reg2), 64'hCAFEF00D);
    chk("adv.hi",    64'(mem_hi), 64'h11111111);
    chk("adv.whilo", 64'(mem_whilo), 64'd0);
    chk("adv.cnt",   64'(cnt_o), 64'd0);
    chk("adv.hilo",  hilo_o, 64'd0);

    // bubble
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    step();
    chk("bub.wreg",  64'(mem_wreg), 64'd0);
    chk("bub.aluop", 64'(mem_aluop), 64'd0);
    chk("bub.wdata", 64'(mem_wdata), 64'd0);
    chk("bub.hilo",  hilo_o, 64'h1_0000_0002);
    chk("bub.cnt",   64'(cnt_o), 64'd1);
    stall = 6'b000000;
    step();
    chk("bub_rel.cnt",  64'(cnt_o), 64'd0);
    chk("bub_rel.hilo", hilo_o, 64'd0);
    chk("bub_rel.wreg", 64'(mem_wreg), 64'd1);

    // hold
    ex_wdata = 32'hA5A5A5A5;
    step();
    chk("hold_ld.wdata", 64'(mem_wdata), 64'hA5A5A5A5);
    stall = 6'b011111; ex_wdata = 32'h0; ex_wd = 5'd9; cnt_i = 2'd2; hilo_i = 64'h0000_0003_0000_0004;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.wdata", 64'(mem_wdata), 64'hA5A5A5A5);
      chk("hold.wd",    64'(mem_wd), 64'd3);
      chk("hold.cnt",   64'(cnt_o), 64'd2);
      chk("hold.hilo",  hilo_o, 64'h0000_0003_0000_0004);
    end
    stall = 6'b000000;
    step();
    chk("hold_rel.wdata", 64'(mem_wdata), 64'd0);
    chk("hold_rel.wd",    64'(mem_wd), 64'd9);
    chk("hold_rel.cnt",   64'(cnt_o), 64'd0);

    // flush beats a hold stall
    stall = 6'b011111; cnt_i = 2'd3; hilo_i = 64'hABCD;
    step();
    flush = 1'b1;
    step();
    chk_all_zero("flush");
    flush = 1'b0; stall = 6'b000000;

    // bits other than 3 and 4 ignored
    stall = 6'b100111; ex_wdata = 32'h0BADC0DE;
    step();
    chk("ign.wdata", 64'(mem_wdata), 64'h0BADC0DE);
    chk("ign.wreg",  64'(mem_wreg), 64'd1);

    // multiply-accumulate: one bubble cycle, then result advances
    stall = 6'b001111; ex_aluop = 8'h28; ex_whilo = 1'b0; cnt_i = 2'd1; hilo_i = 64'h0000_0001_0000_0002;
    step();
    chk("mac1.whilo", 64'(mem_whilo), 64'd0);
    chk("mac1.cnt",   64'(cnt_o), 64'd1);
    chk("mac1.hilo",  hilo_o, 64'h0000_0001_0000_0002);
    stall = 6'b000000; ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2; cnt_i = 2'd0; hilo_i = 64'd0;
    step();
    chk("mac2.whilo", 64'(mem_whilo), 64'd1);
    chk("mac2.hi",    64'(mem_hi), 64'd1);
    chk("mac2.lo",    64'(mem_lo), 64'd2);
    chk("mac2.aluop", 64'(mem_aluop), 64'h28);
    chk("mac2.cnt",   64'(cnt_o), 64'd0);

    // reset wins over a fresh advance
    rst = 1'b1;
    step();
    chk_all_zero("rst3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
